// File: rtl/stk_pipe_pkg.sv
// stk_pipe_pkg: shared types and constants for the stack pipeline tail-pointer path.
package stk_pipe_pkg;
    localparam int N_STK_IDS = 1024;
    typedef logic [9:0] tail_ptr_t;
    typedef logic [9:0] stk_id_t;
    typedef enum logic [1:0] {NOP = 2'b00, RD = 2'b01, WR = 2'b10, XCHG = 2'b11} tail_op_t;
    typedef enum logic [1:0] {INIT, RUN, XWR} ctrl_state_t;
endpackage

// File: rtl/stk_pipe_tail_ctrl.sv
// stk_pipe_tail_ctrl: initialises the tail SRAM, then serialises RD/WR/XCHG commands onto its single port.
module stk_pipe_tail_ctrl
    import stk_pipe_pkg::*;
#(
    parameter int        N_IDS    = N_STK_IDS,
    parameter tail_ptr_t INIT_PTR = 10'h000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_cmd_vld,
    input  logic [1:0] i_cmd_op,
    input  logic [9:0] i_cmd_id,
    input  logic [9:0] i_cmd_ptr,
    output logic       o_cmd_rdy,
    output logic       o_rsp_vld,
    output logic [9:0] o_rsp_id,
    output logic [9:0] o_rsp_ptr,
    output logic       o_init_done,
    output logic       o_err_op,
    output logic [9:0] o_sram_addr,
    output logic [9:0] o_sram_din,
    output logic       o_sram_ce,
    output logic       o_sram_oe,
    input  logic [9:0] i_sram_dout
);
    localparam int AW = $clog2(N_IDS);

    ctrl_state_t state;
    logic [AW:0] cnt;
    tail_op_t    cmd_op, r0_op;
    stk_id_t     r0_id;
    tail_ptr_t   r0_ptr;
    logic        r0_vld, acc;

    assign cmd_op    = tail_op_t'(i_cmd_op);
    assign acc       = i_cmd_vld && o_cmd_rdy;
    // SRAM data arrives the cycle after the read, aligned with the registered response strobe
    assign o_rsp_ptr = i_sram_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= INIT;
            cnt         <= '0;
            r0_vld      <= 1'b0;
            o_cmd_rdy   <= 1'b0;
            o_rsp_vld   <= 1'b0;
            o_init_done <= 1'b0;
            o_err_op    <= 1'b0;
            o_sram_ce   <= 1'b0;
            o_sram_oe   <= 1'b1;
        end else begin
            o_sram_ce <= 1'b0;
            o_sram_oe <= 1'b1;
            r0_vld    <= acc;
            o_err_op  <= acc && cmd_op == NOP;
            o_rsp_vld <= r0_vld && (r0_op == RD || r0_op == XCHG);
            o_rsp_id  <= r0_id;
            if (acc) begin
                r0_op  <= cmd_op;
                r0_id  <= i_cmd_id;
                r0_ptr <= i_cmd_ptr;
            end
            case (state)
                INIT: begin
                    if (cnt[AW]) begin
                        state       <= RUN;
                        o_init_done <= 1'b1;
                        o_cmd_rdy   <= 1'b1;
                    end else begin
                        o_sram_ce   <= 1'b1;
                        o_sram_oe   <= 1'b0;
                        o_sram_addr <= stk_id_t'(cnt[AW-1:0]);
                        o_sram_din  <= INIT_PTR;
                        cnt         <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    if (acc && cmd_op != NOP) begin
                        o_sram_ce   <= 1'b1;
                        o_sram_oe   <= cmd_op != WR;
                        o_sram_addr <= i_cmd_id;
                        o_sram_din  <= i_cmd_ptr;
                    end
                    // exchange holds the port for its write-back cycle
                    if (acc && cmd_op == XCHG) begin
                        state     <= XWR;
                        o_cmd_rdy <= 1'b0;
                    end
                end
                XWR: begin
                    o_sram_ce   <= 1'b1;
                    o_sram_oe   <= 1'b0;
                    o_sram_addr <= r0_id;
                    o_sram_din  <= r0_ptr;
                    state       <= RUN;
                    o_cmd_rdy   <= 1'b1;
                end
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_stk_pipe_tail_ctrl.sv
// tb_stk_pipe_tail_ctrl: randomized and directed bench against a cycle-indexed expectation model.
module tb_stk_pipe_tail_ctrl;
    localparam int N = 1024;
    localparam int MAXC = 8192;
    localparam logic [1:0] OP_NOP = 2'b00, OP_RD = 2'b01, OP_WR = 2'b10, OP_XCHG = 2'b11;

    typedef struct {
        bit rdy, done, err, ce, oe, rv;
        logic [9:0] addr, din, rid, rptr;
    } exp_t;

    logic clk = 1'b0, rst = 1'b1;
    logic cmd_vld = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [9:0] cmd_id = '0, cmd_ptr = '0;
    logic cmd_rdy, rsp_vld, init_done, err_op, sram_ce, sram_oe;
    logic [9:0] rsp_id, rsp_ptr, sram_addr, sram_din;
    logic [9:0] sram_dout;
    logic [9:0] sram [N];

    int passed = 0, total = 0;
    int cyc = 0, init_pos = 0, iw = 0;
    bit started = 0, running = 0, prev_rdy = 0, init_bad = 0, rdy_in_init = 0;
    exp_t ex [MAXC];
    logic [9:0] ref_mem [N];
    logic [19:0] got [$];

    stk_pipe_tail_ctrl dut (
        .clk(clk), .rst(rst),
        .i_cmd_vld(cmd_vld), .i_cmd_op(cmd_op), .i_cmd_id(cmd_id), .i_cmd_ptr(cmd_ptr),
        .o_cmd_rdy(cmd_rdy), .o_rsp_vld(rsp_vld), .o_rsp_id(rsp_id), .o_rsp_ptr(rsp_ptr),
        .o_init_done(init_done), .o_err_op(err_op),
        .o_sram_addr(sram_addr), .o_sram_din(sram_din), .o_sram_ce(sram_ce), .o_sram_oe(sram_oe),
        .i_sram_dout(sram_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk)
        if (sram_ce) begin
            if (sram_oe) sram_dout <= sram[sram_addr];
            else sram[sram_addr] <= sram_din;
        end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, a, e);
    endtask

    // Expected outputs per cycle, derived from accepted commands against a reference table
    always @(posedge clk) begin
        int c, n;
        cyc = cyc + 1;
        c = cyc % MAXC;
        n = (cyc + 1) % MAXC;
        ex[n] = '{default: '0};
        if (rst) begin
            ex[c] = '{default: '0};
            started = 1;
            running = 0;
            init_pos = 0;
            prev_rdy = 0;
            for (int i = 0; i < N; i++) ref_mem[i] = '0;
        end else if (started) begin
            if (!running) begin
                if (init_pos < N) begin
                    ex[c].ce = 1; ex[c].oe = 0; ex[c].addr = 10'(init_pos); ex[c].din = '0;
                    init_pos++;
                end else begin
                    running = 1; ex[c].done = 1; ex[c].rdy = 1;
                end
            end else begin
                ex[c].done = 1;
                ex[c].rdy = 1;
                if (cmd_vld && prev_rdy) begin
                    if (cmd_op == OP_NOP) ex[c].err = 1;
                    else begin
                        ex[c].ce = 1; ex[c].oe = (cmd_op != OP_WR); ex[c].addr = cmd_id; ex[c].din = cmd_ptr;
                        if (cmd_op != OP_WR) begin
                            ex[n].rv = 1; ex[n].rid = cmd_id; ex[n].rptr = ref_mem[cmd_id];
                        end
                        if (cmd_op == OP_XCHG) begin
                            ex[n].ce = 1; ex[n].oe = 0; ex[n].addr = cmd_id; ex[n].din = cmd_ptr;
                            ex[c].rdy = 0;
                        end
                        if (cmd_op != OP_RD) ref_mem[cmd_id] = cmd_ptr;
                    end
                end
            end
            prev_rdy = ex[c].rdy;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            iw = 0; init_bad = 0; rdy_in_init = 0;
        end else if (init_done === 1'b0) begin
            if (sram_ce && !sram_oe) begin
                if (sram_addr !== 10'(iw) || sram_din !== 10'h000) init_bad = 1;
                iw++;
            end
            if (cmd_rdy !== 1'b0) rdy_in_init = 1;
        end
        if (started) begin
            e = ex[cyc % MAXC];
            chk("rdy", 32'(cmd_rdy), 32'(e.rdy));
            chk("init_done", 32'(init_done), 32'(e.done));
            chk("err_op", 32'(err_op), 32'(e.err));
            chk("sram_ce", 32'(sram_ce), 32'(e.ce));
            if (e.ce) begin
                chk("sram_oe", 32'(sram_oe), 32'(e.oe));
                chk("sram_addr", 32'(sram_addr), 32'(e.addr));
                if (!e.oe) chk("sram_din", 32'(sram_din), 32'(e.din));
            end
            chk("rsp_vld", 32'(rsp_vld), 32'(e.rv));
            if (e.rv) begin
                chk("rsp_id", 32'(rsp_id), 32'(e.rid));
                chk("rsp_ptr", 32'(rsp_ptr), 32'(e.rptr));
            end
        end
        if (rsp_vld === 1'b1) got.push_back({rsp_id, rsp_ptr});
    end

    task automatic issue(input logic [1:0] op, input logic [9:0] id, input logic [9:0] ptr);
        bit ok = 0;
        @(negedge clk);
        cmd_vld = 1; cmd_op = op; cmd_id = id; cmd_ptr = ptr;
        for (int i = 0; i < 64; i++) begin
            if (cmd_rdy === 1'b1) begin ok = 1; break; end
            @(negedge clk);
        end
        if (!ok) chk("issue_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        cmd_vld = 0;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic wait_init();
        for (int i = 0; i < 1200 && init_done !== 1'b1; i++) @(negedge clk);
        chk("init_timeout", 32'(init_done), 32'd1);
        chk("init_writes", 32'(iw), 32'd1024);
        chk("init_addr_seq", 32'(init_bad), 32'd0);
        chk("rdy_in_init", 32'(rdy_in_init), 32'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 0;
        wait_init();

        got.delete();
        issue(OP_WR, 10'd5, 10'h2A3);
        issue(OP_RD, 10'd5, 10'h000);
        idle(4);
        chk("wr_rd_count", 32'(got.size()), 32'd1);
        if (got.size() > 0) chk("wr_rd_rsp", 32'(got[0]), {12'h0, 10'd5, 10'h2A3});

        got.delete();
        issue(OP_XCHG, 10'd7, 10'h011);
        issue(OP_RD, 10'd7, 10'h000);
        idle(4);
        chk("xchg_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            chk("xchg_old", 32'(got[0]), {12'h0, 10'd7, 10'h000});
            chk("xchg_new", 32'(got[1]), {12'h0, 10'd7, 10'h011});
        end

        got.delete();
        for (int i = 0; i < 8; i++) issue(OP_RD, 10'(i), 10'h000);
        idle(4);
        chk("rd_stream_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < 8 && i < got.size(); i++) chk("rd_stream_id", 32'(got[i][19:10]), 32'(i));

        for (int i = 0; i < 6; i++) begin
            issue(OP_XCHG, 10'(i), 10'(i * 37 + 1));
            issue(OP_RD, 10'(i), 10'h000);
        end
        idle(3);

        got.delete();
        issue(OP_NOP, 10'd9, 10'h3FF);
        idle(4);
        chk("nop_no_rsp", 32'(got.size()), 32'd0);

        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            cmd_vld = ($urandom_range(0, 3) != 0);
            cmd_op = 2'($urandom_range(0, 3));
            cmd_id = 10'($urandom_range(0, 15));
            cmd_ptr = 10'($urandom);
        end
        idle(4);

        got.delete();
        issue(OP_RD, 10'd3, 10'h000);
        @(negedge clk);
        cmd_vld = 0;
        rst = 1;
        @(negedge clk);
        rst = 0;
        wait_init();
        chk("rst_no_rsp", 32'(got.size()), 32'd0);

        issue(OP_RD, 10'd5, 10'h000);
        issue(OP_WR, 10'd5, 10'h155);
        issue(OP_RD, 10'd5, 10'h000);
        idle(4);
        chk("post_rst_count", 32'(got.size()), 32'd2);
        if (got.size() > 1) begin
            chk("post_rst_init", 32'(got[0]), {12'h0, 10'd5, 10'h000});
            chk("post_rst_wr", 32'(got[1]), {12'h0, 10'd5, 10'h155});
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
